// File: rtl/huffman_stream_decoder_pkg.sv
// Shared types and reset defaults for the canonical Huffman stream decoder.
// Default code set: A=0, B=100, C=101, D=110, E=1110, F=1111 -> symbols 1..6.
package huffman_pkg;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  localparam int DEF_NUM_CODES = 6;

  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  // One extra bit keeps code - first from wrapping into a false match.
  function automatic int arith_w(input int max_len);
    return max_len + 1;
  endfunction

  function automatic int default_count(input int len);
    case (len)
      1:       return 1;
      3:       return 3;
      4:       return 2;
      default: return 0;
    endcase
  endfunction

  function automatic int default_sym(input int idx);
    return (idx < DEF_NUM_CODES) ? idx + 1 : 0;
  endfunction

endpackage

// File: rtl/huffman_stream_decoder_if.sv
// Bit-in / symbol-out stream bundle of the Huffman decoder.
// valid/ready: a transfer happens on a rising edge where valid & ready are both
// high; the source holds data stable while valid & ~ready, ready may depend on valid.
interface huffman_stream_decoder_if #(
  parameter int SYM_W = 3
);
  logic             in_valid;
  logic             in_bit;
  logic             in_ready;
  logic             sym_valid;
  logic [SYM_W-1:0] sym_data;
  logic             sym_ready;
  logic             err;

  modport master (
    output in_valid, in_bit, sym_ready,
    input  in_ready, sym_valid, sym_data, err
  );

  modport slave (
    input  in_valid, in_bit, sym_ready,
    output in_ready, sym_valid, sym_data, err
  );
endinterface

// File: rtl/huffman_stream_decoder_code_table.sv
// Count-per-length and canonical-order symbol register files with reset defaults.
module huffman_code_table
  import huffman_pkg::*;
#(
  parameter int SYM_W   = 3,
  parameter int MAX_LEN = 4,
  localparam int LW     = len_w(MAX_LEN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cnt_we,
  input  logic [LW-1:0]    cnt_len,
  input  logic [SYM_W:0]   cnt_val,
  input  logic             tbl_we,
  input  logic [SYM_W-1:0] tbl_addr,
  input  logic [SYM_W-1:0] tbl_val,
  input  logic [LW-1:0]    rd_len,
  output logic [SYM_W:0]   rd_cnt,
  input  logic [SYM_W-1:0] rd_addr,
  output logic [SYM_W-1:0] rd_sym
);
  localparam int NSYM = 2 ** SYM_W;
  localparam int NCNT = 2 ** LW;
  localparam int CW   = SYM_W + 1;

  // Sized to the full index range so every read is in bounds; unused lengths stay 0.
  logic [SYM_W:0]   cnt_q [NCNT];
  logic [SYM_W:0]   cnt_d [NCNT];
  logic [SYM_W-1:0] tbl_q [NSYM];
  logic [SYM_W-1:0] tbl_d [NSYM];

  always_comb begin
    cnt_d = cnt_q;
    tbl_d = tbl_q;
    if (cnt_we && (cnt_len != '0) && (cnt_len <= LW'(MAX_LEN))) cnt_d[cnt_len] = cnt_val;
    if (tbl_we) tbl_d[tbl_addr] = tbl_val;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCNT; i++) cnt_q[i] <= CW'((i <= MAX_LEN) ? default_count(i) : 0);
      for (int i = 0; i < NSYM; i++) tbl_q[i] <= SYM_W'(default_sym(i));
    end else begin
      cnt_q <= cnt_d;
      tbl_q <= tbl_d;
    end
  end

  assign rd_cnt = cnt_q[rd_len];
  assign rd_sym = tbl_q[rd_addr];

endmodule

// File: rtl/huffman_stream_decoder.sv
// Canonical Huffman decoder: one code bit per accepted transfer, one-entry
// symbol output buffer, err pulse when MAX_LEN bits fail to match any code.
module huffman_stream_decoder
  import huffman_pkg::*;
#(
  parameter int SYM_W   = 3,
  parameter int MAX_LEN = 4,
  localparam int LW     = len_w(MAX_LEN)
) (
  input  logic                     clk,
  input  logic                     reset,
  huffman_stream_decoder_if.slave  bus,
  input  logic                     cnt_we,
  input  logic [LW-1:0]            cnt_len,
  input  logic [SYM_W:0]           cnt_val,
  input  logic                     tbl_we,
  input  logic [SYM_W-1:0]         tbl_addr,
  input  logic [SYM_W-1:0]         tbl_val,
  output state_e                   state_dbg
);
  localparam int W    = arith_w(MAX_LEN);
  localparam int NSYM = 2 ** SYM_W;

  state_e           state_q, state_d;
  logic [W-1:0]     code_q, code_d, first_q, first_d, index_q, index_d;
  logic [LW-1:0]    len_q, len_d;
  logic             sym_valid_q, sym_valid_d;
  logic [SYM_W-1:0] sym_data_q, sym_data_d;
  logic             err_q, err_d;

  logic             cfg_we, accept, pop, hit;
  logic [W-1:0]     code_n, diff, cnt_w, addr_w;
  logic [LW-1:0]    len_n;
  logic [SYM_W:0]   rd_cnt;
  logic [SYM_W-1:0] rd_sym;

  // A config write owns the cycle: the offered bit is refused, not silently lost.
  assign cfg_we       = cnt_we | tbl_we;
  assign bus.in_ready = (~sym_valid_q | bus.sym_ready) & ~cfg_we;
  assign accept       = bus.in_valid & bus.in_ready;
  assign pop          = sym_valid_q & bus.sym_ready;

  assign code_n = (code_q << 1) | W'(bus.in_bit);
  assign len_n  = len_q + LW'(1);
  assign cnt_w  = W'(rd_cnt);
  assign diff   = code_n - first_q;
  assign addr_w = index_q + diff;
  assign hit    = (diff < cnt_w) && (32'(addr_w) < NSYM);

  huffman_code_table #(
    .SYM_W   (SYM_W),
    .MAX_LEN (MAX_LEN)
  ) u_table (
    .clk      (clk),
    .reset    (reset),
    .cnt_we   (cnt_we),
    .cnt_len  (cnt_len),
    .cnt_val  (cnt_val),
    .tbl_we   (tbl_we),
    .tbl_addr (tbl_addr),
    .tbl_val  (tbl_val),
    .rd_len   (len_n),
    .rd_cnt   (rd_cnt),
    .rd_addr  (SYM_W'(addr_w)),
    .rd_sym   (rd_sym)
  );

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    first_d     = first_q;
    index_d     = index_q;
    len_d       = len_q;
    sym_valid_d = sym_valid_q;
    sym_data_d  = sym_data_q;
    err_d       = 1'b0;

    if (pop) begin
      sym_valid_d = 1'b0;
      state_d     = ST_ACC;
    end

    if (cfg_we) begin
      code_d  = '0;
      first_d = '0;
      index_d = '0;
      len_d   = '0;
    end else if (accept) begin
      if (hit) begin
        sym_data_d  = rd_sym;
        sym_valid_d = 1'b1;
        state_d     = ST_HOLD;
        code_d      = '0;
        first_d     = '0;
        index_d     = '0;
        len_d       = '0;
      end else if (len_n == LW'(MAX_LEN)) begin
        err_d   = 1'b1;
        code_d  = '0;
        first_d = '0;
        index_d = '0;
        len_d   = '0;
      end else begin
        index_d = index_q + cnt_w;
        first_d = (first_q + cnt_w) << 1;
        code_d  = code_n;
        len_d   = len_n;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_ACC;
      code_q      <= '0;
      first_q     <= '0;
      index_q     <= '0;
      len_q       <= '0;
      sym_valid_q <= 1'b0;
      sym_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      first_q     <= first_d;
      index_q     <= index_d;
      len_q       <= len_d;
      sym_valid_q <= sym_valid_d;
      sym_data_q  <= sym_data_d;
      err_q       <= err_d;
    end
  end

  assign bus.sym_valid = sym_valid_q;
  assign bus.sym_data  = sym_data_q;
  assign bus.err       = err_q;
  assign state_dbg     = state_q;

endmodule
